tx_response_packer: RTL

Byte-oriented response buffer in the REF_CLK domain between the register file/ALU result path and the UART transmit data synchronizer. It captures 8-bit register read data and 16-bit ALU results into a small byte FIFO. It then drains the bytes one at a time onto the TX byte interface, using a level valid / busy-acknowledge handshake that survives the REF_CLK→TX_CLK synchronizers.

---
 rtl/tx_response_packer_if.sv | 27 ++
 rtl/tx_response_packer.sv | 109 ++++++++++
 2 files changed

// File: rtl/tx_response_packer_if.sv
// Byte-response bus between the result path, the response packer and the TX data synchronizer.
// The slave side is the packer; the master side is whatever produces results and consumes TX bytes.
interface tx_response_packer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RdData;
    logic                     RdData_Valid;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VALID;
    logic                     TX_Busy;
    logic [DATA_WIDTH-1:0]    TX_P_DATA;
    logic                     TX_DATA_VALID;
    logic                     FIFO_EMPTY;
    logic                     FIFO_FULL;
    logic                     OVERFLOW;

    modport master (
        output RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID, TX_Busy,
        input  TX_P_DATA, TX_DATA_VALID, FIFO_EMPTY, FIFO_FULL, OVERFLOW
    );

    modport slave (
        input  RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID, TX_Busy,
        output TX_P_DATA, TX_DATA_VALID, FIFO_EMPTY, FIFO_FULL, OVERFLOW
    );
endinterface

// File: rtl/tx_response_packer.sv
// Byte FIFO that packs register reads and 16-bit ALU results, then drains them one byte at a time
// to the TX synchronizer with a level-valid / busy-acknowledge handshake.
module tx_response_packer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int PTR_WIDTH     = 2
) (
    input  logic                CLK,
    input  logic                RST,
    tx_response_packer_if.slave bus
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [PTR_WIDTH-1:0]  alu_addr_lo, alu_addr_hi;
    logic [PTR_WIDTH:0]    count, free_cnt, free_after_rd, push_cnt;
    logic [1:0]            state;
    logic                  rd_ok, alu_ok, drop, pop;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid, overflow_q;

    // Admission: RdData claims space first, the ALU pair only if both bytes still fit.
    // NOTE: every always_comb output gets a value up front, so no path can infer a latch.
    always_comb begin
        free_cnt      = DEPTH_CNT - count;
        rd_ok         = bus.RdData_Valid && (free_cnt != '0);
        free_after_rd = free_cnt - (PTR_WIDTH+1)'(rd_ok);
        alu_ok        = bus.ALU_OUT_VALID && (free_after_rd >= (PTR_WIDTH+1)'(2));
        drop          = (bus.RdData_Valid && !rd_ok) || (bus.ALU_OUT_VALID && !alu_ok);
        push_cnt      = (PTR_WIDTH+1)'(rd_ok) + (alu_ok ? (PTR_WIDTH+1)'(2) : '0);
        pop           = (state == SEND) && bus.TX_Busy;
        alu_addr_lo   = wr_ptr + PTR_WIDTH'(rd_ok);
        alu_addr_hi   = alu_addr_lo + PTR_WIDTH'(1);
    end

    // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge CLK) begin
        if (rd_ok) begin
            mem[wr_ptr] <= bus.RdData;
        end
        if (alu_ok) begin
            mem[alu_addr_lo] <= bus.ALU_OUT[DATA_WIDTH-1:0];
            mem[alu_addr_hi] <= bus.ALU_OUT[ALU_OUT_WIDTH-1:DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_WIDTH'(push_cnt);
            rd_ptr     <= rd_ptr + PTR_WIDTH'(pop);
            count      <= count + push_cnt - (PTR_WIDTH+1)'(pop);
            overflow_q <= drop;
        end
    end

    // Drain FSM: loads only from the registered head, pops on the edge that sees TX_Busy high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((count != '0) && !bus.TX_Busy) begin
                        tx_data  <= mem[rd_ptr];
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bus.TX_Busy) begin
                        tx_valid <= 1'b0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TX_Busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX_P_DATA     = tx_data;
    assign bus.TX_DATA_VALID = tx_valid;
    assign bus.OVERFLOW      = overflow_q;
    assign bus.FIFO_EMPTY    = (count == '0);
    assign bus.FIFO_FULL     = (count == DEPTH_CNT);

endmodule
